uart_rx_core: RTL and testbench

//  UART receiver, 16x oversampled. Paired with uart_tx on the FPGA input pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_baud_tick.sv | 32 +++
 rtl/uart_rx_core.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and baud divisor helper.
package uart_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SC_W     = 4;
  localparam int unsigned BITCNT_W = 3;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate,
                                           input int unsigned oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 while enabled, one-cycle tick at DIV-1.
module uart_baud_tick #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = '0;
    tick_c = 1'b0;
    if (en) begin
      if (cnt_q == CW'(DIV - 1)) begin
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// 16x oversampled UART receiver: start, 8 data LSB first, parity, stop.
// RX_MAJORITY_VOTE_EN: 2-of-3 vote over samples 6,7,8 instead of a single sample at 7.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rx_line,
  input  logic              parity_mode,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              rx_busy
);

  localparam int unsigned DIV       = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int unsigned DECIDE_SC = 8;

`ifdef RX_MAJORITY_VOTE_EN
  localparam int unsigned SAMP_W = 2;
`else
  localparam int unsigned SAMP_W = 1;
`endif

  logic                sync1_q, rxs_q;
  rx_state_e           state_q, state_d;
  logic [SC_W-1:0]     sc_q, sc_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [SAMP_W-1:0]   samp_q, samp_d;
  logic                mode_q, mode_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                parity_err_q, parity_err_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;
  logic                tick_c, decide_c, bit_val_c;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rstn   (rstn),
    .en     (state_q != IDLE),
    .tick_c (tick_c)
  );

  // Bits are resolved at the sc=8 tick in both builds so timing never depends on the vote option.
  assign decide_c = tick_c && (sc_q == SC_W'(DECIDE_SC));

`ifdef RX_MAJORITY_VOTE_EN
  assign bit_val_c = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxs_q) | (samp_q[0] & rxs_q);
`else
  assign bit_val_c = samp_q[0];
`endif

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    samp_d       = samp_q;
    mode_d       = mode_q;
    perr_d       = perr_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    if (tick_c) begin
      sc_d   = sc_q + SC_W'(1);
      samp_d = SAMP_W'({samp_q, rxs_q});
    end

    case (state_q)
      IDLE: begin
        sc_d = '0;
        if (!rxs_q) begin
          state_d = START;
          mode_d  = parity_mode;
        end
      end
      START: begin
        if (decide_c) begin
          bit_cnt_d = '0;
          state_d   = bit_val_c ? IDLE : DATA;
        end
      end
      DATA: begin
        if (decide_c) begin
          shreg_d   = {bit_val_c, shreg_q[DATA_W-1:1]};
          bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
          if (bit_cnt_q == BITCNT_W'(DATA_W - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (decide_c) begin
          perr_d  = ((^shreg_q) ^ bit_val_c) != mode_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (decide_c) begin
          rx_valid_d   = 1'b1;
          rx_data_d    = shreg_q;
          parity_err_d = perr_q;
          frame_err_d  = !bit_val_c;
          state_d      = bit_val_c ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= IDLE;
      sc_q         <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      samp_q       <= '0;
      mode_q       <= 1'b0;
      perr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= rx_line;
      rxs_q        <= sync1_q;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      samp_q       <= samp_d;
      mode_q       <= mode_d;
      perr_q       <= perr_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized self-checking bench for uart_rx_core against a frame-level reference model.
module tb_uart_rx_core;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 25_000;
  localparam int unsigned OVS      = 16;
  localparam int unsigned BIT_CLK  = CLK_FREQ / BAUD;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx_line = 1'b1;
  logic       parity_mode = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int pushed = 0;
  logic prev_valid = 1'b0;
  logic [9:0] exp_e;
  logic [9:0] exp_q[$];

  uart_rx_core #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OVS)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_line     (rx_line),
    .parity_mode (parity_mode),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Delivered bytes are matched in order against the frames the driver has sent.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      check("valid_pulse_width", 32'(prev_valid), 32'd0);
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_e = exp_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(exp_e[7:0]));
        check("parity_err", 32'(parity_err), 32'(exp_e[8]));
        check("frame_err", 32'(frame_err), 32'(exp_e[9]));
      end
    end
    prev_valid = rx_valid;
  end

  // Drives one frame; parity bit is correct for 'mode' unless pflip; stop=0 holds the line low extra bits.
  task automatic send_frame(input logic [7:0] d, input logic mode, input logic pflip,
                            input logic stop, input int extra_low, input logic chg_mode,
                            input int glitch_bit);
    logic p;
    logic exp_perr;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    p = ((ones % 2) == 1) ^ mode ^ pflip;
    exp_perr = (((ones + int'(p)) % 2) == 1) != mode;
    exp_q.push_back({!stop, exp_perr, d});
    pushed++;
    parity_mode = mode;
    @(posedge clk);
    rx_line = 1'b0;
    wait_clk(BIT_CLK);
    if (chg_mode) parity_mode = !mode;
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      wait_clk(BIT_CLK / 2 - 1);
      if (i == glitch_bit) begin
        rx_line = !d[i];
        wait_clk(2);
        rx_line = d[i];
      end else begin
        wait_clk(2);
      end
      if (i == 4) check("busy_mid_frame", 32'(rx_busy), 32'd1);
      wait_clk(BIT_CLK - BIT_CLK / 2 - 1);
    end
    rx_line = p;
    wait_clk(BIT_CLK);
    rx_line = stop;
    wait_clk(BIT_CLK);
    if (!stop) begin
      wait_clk(extra_low * BIT_CLK);
      rx_line = 1'b1;
    end
  endtask

  initial begin
    int snap;
    logic [7:0] d;
    logic st;

    wait_clk(3);
    @(negedge clk);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_flags", 32'({parity_err, frame_err}), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    rstn = 1'b1;
    wait_clk(2 * BIT_CLK);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
    wait_clk(BIT_CLK);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 0, 1'b0, -1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
    wait_clk(BIT_CLK);
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 0, 1'b0, -1);
    wait_clk(BIT_CLK);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 2, 1'b0, -1);
    wait_clk(2 * BIT_CLK);
    send_frame(8'h3E, 1'b1, 1'b0, 1'b1, 0, 1'b1, -1);
    wait_clk(2 * BIT_CLK);
    check("directed_count", 32'(valid_cnt), 32'(pushed));

    // Short low glitch on an idle line must be rejected at the start check.
    snap = valid_cnt;
    @(posedge clk);
    rx_line = 1'b0;
    wait_clk(6);
    @(negedge clk);
    check("glitch_busy_rise", 32'(rx_busy), 32'd1);
    wait_clk(4);
    rx_line = 1'b1;
    wait_clk(BIT_CLK);
    @(negedge clk);
    check("glitch_busy_fall", 32'(rx_busy), 32'd0);
    check("glitch_no_valid", 32'(valid_cnt), 32'(snap));

    // Reset pulse in the middle of data bit 4 of 8'hC3 drops the frame.
    snap = valid_cnt;
    d = 8'hC3;
    parity_mode = 1'b0;
    @(posedge clk);
    rx_line = 1'b0;
    wait_clk(BIT_CLK);
    for (int i = 0; i < 4; i++) begin
      rx_line = d[i];
      wait_clk(BIT_CLK);
    end
    rx_line = d[4];
    wait_clk(BIT_CLK / 2);
    rstn = 1'b0;
    rx_line = 1'b1;
    @(posedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_flags", 32'({rx_valid, parity_err, frame_err}), 32'd0);
    check("midrst_busy", 32'(rx_busy), 32'd0);
    wait_clk(12 * BIT_CLK);
    check("midrst_no_valid", 32'(valid_cnt), 32'(snap));
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
    wait_clk(BIT_CLK);

`ifdef RX_MAJORITY_VOTE_EN
    send_frame(8'h6D, 1'b0, 1'b0, 1'b1, 0, 1'b0, 3);
    wait_clk(BIT_CLK);
`endif

    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      st = ($urandom_range(7) != 0);
      send_frame(d, 1'($urandom_range(1)), ($urandom_range(3) == 0), st,
                 int'($urandom_range(3)), 1'($urandom_range(1)), -1);
      if (!st) wait_clk(BIT_CLK);
      wait_clk(int'($urandom_range(2)) * BIT_CLK);
    end

    wait_clk(2 * BIT_CLK);
    check("all_delivered", 32'(exp_q.size()), 32'd0);
    check("valid_total", 32'(valid_cnt), 32'(pushed));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
